// File: rtl/outbound_fifo_reader_if.sv
// Byte stream from the outbound FIFO reader to the port transmitter.
// The master drives payload, end-of-frame and valid; the slave returns ready.
interface outbound_fifo_reader_if #(
    parameter int unsigned DATA_WIDTH = 9
);
    logic [DATA_WIDTH-2:0] m_data;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, output m_last, output m_valid, input m_ready);
    modport slave  (input m_data, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/outbound_fifo_reader.sv
// Read side of the outbound frame FIFO: issues LSRAM reads and absorbs the read
// latency in a 3-entry buffer feeding a valid/ready byte stream.
module outbound_fifo_reader #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   write_pointer,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic                  ram_read_enable,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    input  logic                  flush,
    outbound_fifo_reader_if.master stream
);
    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned BUF_DEPTH = 3;

    logic [PTR_WIDTH-1:0]  issue_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  in_flight;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] entry [BUF_DEPTH];

    logic [1:0]            count_n;
    logic [DATA_WIDTH-1:0] entry_n [BUF_DEPTH];
    logic                  issue;
    logic                  pop;

    // Never let buffered plus in-flight words exceed the buffer, so a capture always has a slot.
    assign issue = (issue_ptr != write_pointer)
                && ((3'({1'b0, count}) + 3'({2'b00, in_flight})) < 3'(BUF_DEPTH))
                && !flush;
    assign pop   = (count != 2'd0) && stream.m_ready && !flush;

    assign ram_read_enable  = issue;
    assign ram_read_address = issue_ptr[ADDR_WIDTH-1:0];
    assign read_pointer     = rd_ptr;
    assign occupancy        = write_pointer - rd_ptr;

    // Head is always entry 0, so the stream outputs come straight from a register.
    assign stream.m_valid = (count != 2'd0);
    assign stream.m_data  = entry[0][DATA_WIDTH-2:0];
    assign stream.m_last  = entry[0][DATA_WIDTH-1];

    // Shift-on-pop buffer; a capture lands at the first free slot after any pop.
    always_comb begin
        count_n = count;
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            entry_n[i] = entry[i];
        end
        if (pop) begin
            entry_n[0] = entry[1];
            entry_n[1] = entry[2];
            count_n    = count - 2'd1;
        end
        if (in_flight) begin
            entry_n[count_n] = ram_read_data;
            count_n          = count_n + 2'd1;
        end
        if (flush) begin
            count_n = 2'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_ptr <= '0;
            rd_ptr    <= '0;
            in_flight <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                entry[i] <= '0;
            end
        end else begin
            count <= count_n;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                entry[i] <= entry_n[i];
            end
            if (flush) begin
                issue_ptr <= write_pointer;
                rd_ptr    <= write_pointer;
                in_flight <= 1'b0;
            end else begin
                in_flight <= issue;
                if (issue) begin
                    issue_ptr <= issue_ptr + PTR_WIDTH'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_outbound_fifo_reader.sv
// Directed and randomised bench for outbound_fifo_reader with a queue-based
// reference of the written byte stream and a 1-cycle-latency RAM model.
module tb_outbound_fifo_reader;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 9;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW:0]   write_pointer;
    logic [AW:0]   read_pointer;
    logic [AW:0]   occupancy;
    logic [AW-1:0] ram_read_address;
    logic          ram_read_enable;
    logic [DW-1:0] ram_read_data;
    logic          flush;

    outbound_fifo_reader_if #(.DATA_WIDTH(DW)) s_if ();

    outbound_fifo_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .write_pointer   (write_pointer),
        .read_pointer    (read_pointer),
        .occupancy       (occupancy),
        .ram_read_address(ram_read_address),
        .ram_read_enable (ram_read_enable),
        .ram_read_data   (ram_read_data),
        .flush           (flush),
        .stream          (s_if.master)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [8192];
    always @(posedge clock) begin
        if (ram_read_enable) ram_read_data <= mem[ram_read_address];
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [AW:0]   model_rp = '0;
    int unsigned   pops = 0;
    int unsigned   written = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Place n words at the current write pointer, then publish them in one step.
    task automatic write_words(input logic [DW-1:0] w [$]);
        logic [AW:0] p;
        p = write_pointer;
        foreach (w[i]) begin
            mem[p[AW-1:0]] = w[i];
            exp_q.push_back(w[i]);
            p = p + 1'b1;
            written++;
        end
        write_pointer = p;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        write_pointer = '0;
        flush         = 1'b0;
        s_if.m_ready  = 1'b0;
        exp_q.delete();
        model_rp = '0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Reference checker: stream order, committed pointer, occupancy and stall stability.
    logic          prev_stall = 1'b0;
    logic [DW-2:0] prev_data;
    logic          prev_last;
    always @(negedge clock) begin
        if (reset_n) begin
            check("read_pointer", 32'(read_pointer), 32'(model_rp));
            check("occupancy", 32'(occupancy), 32'(write_pointer - model_rp));
            check("occ_bound", 32'(occupancy <= 14'd8192), 32'd1);
            if (prev_stall) begin
                check("stall_valid", 32'(s_if.m_valid), 32'd1);
                check("stall_data", 32'({s_if.m_last, s_if.m_data}), 32'({prev_last, prev_data}));
            end
            if (s_if.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    check("stream_word", 32'({s_if.m_last, s_if.m_data}), 32'(exp_q[0]));
                end
            end
            prev_stall = s_if.m_valid && !s_if.m_ready && !flush;
            prev_data  = s_if.m_data;
            prev_last  = s_if.m_last;
            if (flush) begin
                exp_q.delete();
                model_rp = write_pointer;
            end else if (s_if.m_valid && s_if.m_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                model_rp = model_rp + 1'b1;
                pops++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic [DW-1:0] words [$];
        logic [DW-1:0] pre [$];
        logic [AW-1:0] addrs [$];
        int            ren_count;
        int            cyc;

        pre = '{9'h011, 9'h022, 9'h033, 9'h144};
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        do_reset();

        // Reset state
        @(negedge clock);
        check("rst_valid", 32'(s_if.m_valid), 32'd0);
        check("rst_ren", 32'(ram_read_enable), 32'd0);
        check("rst_rp", 32'(read_pointer), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_data", 32'({s_if.m_last, s_if.m_data}), 32'd0);

        // Four words, consumer always ready: cycles 0..5 after the pointer step
        tick(1);
        s_if.m_ready = 1'b1;
        write_words(pre);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check($sformatf("lat_ren_c%0d", c), 32'(ram_read_enable), 32'(c < 4));
            check($sformatf("lat_valid_c%0d", c), 32'(s_if.m_valid), 32'(c >= 2));
            if (c >= 2) begin
                check($sformatf("lat_data_c%0d", c), 32'(s_if.m_data), 32'(pre[c-2][7:0]));
                check($sformatf("lat_last_c%0d", c), 32'(s_if.m_last), 32'(c == 5));
            end
        end
        tick(3);
        check("burst_rp", 32'(read_pointer), 32'd4);

        // Same preload with the consumer stalled
        do_reset();
        write_words(pre);
        ren_count = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (ram_read_enable) ren_count++;
        end
        check("stall_issues", 32'(ren_count), 32'd3);
        check("stall_ren_off", 32'(ram_read_enable), 32'd0);
        check("stall_head_valid", 32'(s_if.m_valid), 32'd1);
        check("stall_head_data", 32'(s_if.m_data), 32'h11);
        check("stall_occ", 32'(occupancy), 32'd4);
        @(posedge clock); #1;
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("resume_valid_%0d", c), 32'(s_if.m_valid), 32'd1);
            check($sformatf("resume_data_%0d", c), 32'(s_if.m_data), 32'(pre[c][7:0]));
        end
        tick(2);

        // Pointer wrap across address 8191
        do_reset();
        write_pointer = 14'h1FFE;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        s_if.m_ready = 1'b1;
        words = '{9'h0A1, 9'h0B2, 9'h1C3};
        write_words(words);
        check("wrap_wp", 32'(write_pointer), 32'h2001);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ram_read_enable) addrs.push_back(ram_read_address);
        end
        check("wrap_issue_count", 32'(addrs.size()), 32'd3);
        if (addrs.size() == 3) begin
            check("wrap_addr0", 32'(addrs[0]), 32'd8190);
            check("wrap_addr1", 32'(addrs[1]), 32'd8191);
            check("wrap_addr2", 32'(addrs[2]), 32'd0);
        end
        check("wrap_rp", 32'(read_pointer), 32'h2001);

        // Flush with ten words pending
        do_reset();
        words.delete();
        for (int i = 0; i < 10; i++) words.push_back(9'(i + 1));
        write_words(words);
        tick(6);
        flush = 1'b1;
        @(negedge clock);
        check("flush_ren", 32'(ram_read_enable), 32'd0);
        tick(1);
        flush = 1'b0;
        @(negedge clock);
        check("flush_valid", 32'(s_if.m_valid), 32'd0);
        check("flush_rp", 32'(read_pointer), 32'd10);
        check("flush_occ", 32'(occupancy), 32'd0);
        ren_count = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (ram_read_enable) ren_count++;
        end
        check("flush_no_reads", 32'(ren_count), 32'd0);

        // Random bursts against a randomly stalling consumer
        do_reset();
        written = 0;
        pops = 0;
        cyc = 0;
        while (pops < 5000 && cyc < 60000) begin
            s_if.m_ready = 1'($urandom_range(0, 1));
            if (written < 5000 && $urandom_range(0, 3) == 0) begin
                int unsigned n;
                logic [AW:0] used;
                n = $urandom_range(1, 8);
                if (n > 5000 - written) n = 5000 - written;
                used = write_pointer - read_pointer;
                if (n <= 8192 - int'(used)) begin
                    words.delete();
                    for (int i = 0; i < int'(n); i++) words.push_back(9'($urandom_range(0, 511)));
                    write_words(words);
                end
            end
            tick(1);
            cyc++;
        end
        if (cyc >= 60000) check("random_timeout", 32'(pops), 32'd5000);
        tick(4);
        check("random_pops", 32'(pops), 32'd5000);
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_rp", 32'(read_pointer), 32'(write_pointer));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
